// File: rtl/top_mul_pipe_mac_if.sv
// Operand/result handshake bundle for top_mul_pipe_mac.
//   master: drives operand beats and out_ready, sees in_ready and results.
//   slave : the multiplier/MAC block itself.
interface top_mul_pipe_mac_if #(
  parameter int unsigned DIN0_WIDTH = 64,
  parameter int unsigned DIN1_WIDTH = 64,
  parameter int unsigned DOUT_WIDTH = 64
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DIN0_WIDTH-1:0] din0;
  logic [DIN1_WIDTH-1:0] din1;
  logic                  is_signed;
  logic                  acc_en;
  logic                  acc_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [DOUT_WIDTH-1:0] dout;
  logic                  dout_last;

  modport master (
    output in_valid, din0, din1, is_signed, acc_en, acc_last, out_ready,
    input  in_ready, out_valid, dout, dout_last
  );

  modport slave (
    input  in_valid, din0, din1, is_signed, acc_en, acc_last, out_ready,
    output in_ready, out_valid, dout, dout_last
  );
endinterface

// File: rtl/top_mul_pipe_mac.sv
// Pipelined multiplier / dot-product accumulator for the GEMV datapath.
// Ports:
//   ap_clk, ap_rst_n : clock, asynchronous active-low reset
//   bus (slave)      : in_valid/in_ready operand beat (din0, din1, is_signed,
//                      acc_en, acc_last), out_valid/out_ready result beat
//                      (dout, dout_last)
// Parameters: DIN0_WIDTH, DIN1_WIDTH, DOUT_WIDTH, NUM_STAGE (1..8).
// Optional feature: define TOP_MAC_SATURATE_EN for saturating accumulate adds.
module top_mul_pipe_mac #(
  parameter int unsigned DIN0_WIDTH = 64,
  parameter int unsigned DIN1_WIDTH = 64,
  parameter int unsigned DOUT_WIDTH = 64,
  parameter int unsigned NUM_STAGE  = 3
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  top_mul_pipe_mac_if.slave bus
);

  localparam int unsigned PW = DIN0_WIDTH + DIN1_WIDTH;
  localparam int unsigned DW = DOUT_WIDTH;

  if (NUM_STAGE < 1 || NUM_STAGE > 8) begin : g_bad_stage
    $error("top_mul_pipe_mac: NUM_STAGE must be within 1..8");
  end

  logic          ce;
  logic          out_valid_q;
  logic          dout_last_q;
  logic [DW-1:0] dout_q;
  logic [DW-1:0] acc_q;

  // Single global enable: the whole pipe moves only when the output slot frees
  assign ce           = ~out_valid_q | bus.out_ready;
  assign bus.in_ready = ce;
  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
  assign bus.dout_last = dout_last_q;

  // Beat presented to the final stage
  logic                  f_v;
  logic                  f_sgn;
  logic                  f_en;
  logic                  f_last;
  logic [DIN0_WIDTH-1:0] f_din0;
  logic [DIN1_WIDTH-1:0] f_din1;

  if (NUM_STAGE == 1) begin : g_s1
    assign f_v    = bus.in_valid;
    assign f_sgn  = bus.is_signed;
    assign f_en   = bus.acc_en;
    assign f_last = bus.acc_last;
    assign f_din0 = bus.din0;
    assign f_din1 = bus.din1;
  end else begin : g_pipe
    localparam int unsigned NR = NUM_STAGE - 1;
    logic [NR-1:0]         v_q;
    logic [NR-1:0]         sgn_q;
    logic [NR-1:0]         en_q;
    logic [NR-1:0]         last_q;
    logic [DIN0_WIDTH-1:0] a_q [NR];
    logic [DIN1_WIDTH-1:0] b_q [NR];

    // Operand delay line ahead of the multiplier; left for retiming to balance
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        v_q    <= '0;
        sgn_q  <= '0;
        en_q   <= '0;
        last_q <= '0;
        for (int i = 0; i < int'(NR); i++) begin
          a_q[i] <= '0;
          b_q[i] <= '0;
        end
      end else if (ce) begin
        v_q[0]    <= bus.in_valid;
        sgn_q[0]  <= bus.is_signed;
        en_q[0]   <= bus.acc_en;
        last_q[0] <= bus.acc_last;
        a_q[0]    <= bus.din0;
        b_q[0]    <= bus.din1;
        for (int i = 1; i < int'(NR); i++) begin
          v_q[i]    <= v_q[i-1];
          sgn_q[i]  <= sgn_q[i-1];
          en_q[i]   <= en_q[i-1];
          last_q[i] <= last_q[i-1];
          a_q[i]    <= a_q[i-1];
          b_q[i]    <= b_q[i-1];
        end
      end
    end

    assign f_v    = v_q[NR-1];
    assign f_sgn  = sgn_q[NR-1];
    assign f_en   = en_q[NR-1];
    assign f_last = last_q[NR-1];
    assign f_din0 = a_q[NR-1];
    assign f_din1 = b_q[NR-1];
  end

  // Full-width product; low PW bits are identical for signed and unsigned
  logic [PW-1:0] a_ext;
  logic [PW-1:0] b_ext;
  logic [PW-1:0] prod_full;
  logic [DW-1:0] f_prod;

  assign a_ext     = {{DIN1_WIDTH{f_sgn & f_din0[DIN0_WIDTH-1]}}, f_din0};
  assign b_ext     = {{DIN0_WIDTH{f_sgn & f_din1[DIN1_WIDTH-1]}}, f_din1};
  assign prod_full = a_ext * b_ext;

  if (DW <= PW) begin : g_trunc
    assign f_prod = DW'(prod_full);
  end else begin : g_ext
    assign f_prod = {{(DW-PW){f_sgn & prod_full[PW-1]}}, prod_full};
  end

  logic [DW-1:0] add_res;

`ifdef TOP_MAC_SATURATE_EN
  logic          sat_q;
  logic          add_sat;
  logic [DW:0]   usum;

  // Saturating add; a clamped partial sum stays clamped until the group closes
  always_comb begin
    usum    = {1'b0, acc_q} + {1'b0, f_prod};
    add_res = usum[DW-1:0];
    add_sat = 1'b0;
    if (sat_q) begin
      add_res = acc_q;
      add_sat = 1'b1;
    end else if (f_sgn) begin
      if ((acc_q[DW-1] == f_prod[DW-1]) && (usum[DW-1] != acc_q[DW-1])) begin
        add_res = acc_q[DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        add_sat = 1'b1;
      end
    end else if (usum[DW]) begin
      add_res = '1;
      add_sat = 1'b1;
    end
  end

  // Sticky clamp flag for the open group
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      sat_q <= 1'b0;
    end else if (ce && f_v && f_en) begin
      sat_q <= f_last ? 1'b0 : add_sat;
    end
  end
`else
  assign add_res = acc_q + f_prod;
`endif

  // Final stage: emit product, fold into partial sum, or close the group
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid_q <= 1'b0;
      dout_last_q <= 1'b0;
      dout_q      <= '0;
      acc_q       <= '0;
    end else if (ce) begin
      if (!f_v) begin
        out_valid_q <= 1'b0;
      end else if (!f_en) begin
        dout_q      <= f_prod;
        out_valid_q <= 1'b1;
        dout_last_q <= 1'b0;
      end else if (!f_last) begin
        acc_q       <= add_res;
        out_valid_q <= 1'b0;
      end else begin
        dout_q      <= add_res;
        out_valid_q <= 1'b1;
        dout_last_q <= 1'b1;
        acc_q       <= '0;
      end
    end
  end

endmodule
